// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
// ------------------------------------------------------------------------
// Command-side initiator for a combinational ALU. It accepts register-based
// ALU commands on a valid/ready channel and keeps a 4-entry register file
// (r0 is hard-wired to zero). For each command it drives registered operands
// and an opcode to the ALU. One cycle later it captures the ALU result and
// writes it back. The result is then returned on a valid/ready response
// channel. Only one command is in flight at a time.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   cmd_valid / cmd_ready      command handshake
//   cmd_op, cmd_dst, cmd_src1, cmd_src2, cmd_use_imm, cmd_imm
//                              command fields (opcode, register indices,
//                              immediate select and immediate value)
//   alu_operand1/2, alu_aluop  registered ALU inputs
//   alu_result, alu_overflow   combinational ALU outputs
//   rsp_valid / rsp_ready      response handshake
//   rsp_data, rsp_overflow     captured result and masked overflow
//   ovf_sticky, ovf_clear      sticky overflow flag and its clear
// ------------------------------------------------------------------------
module alu_cmd_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [1:0]       cmd_dst,
    input  logic [1:0]       cmd_src1,
    input  logic [1:0]       cmd_src2,
    input  logic             cmd_use_imm,
    input  logic [WIDTH-1:0] cmd_imm,
    output logic [WIDTH-1:0] alu_operand1,
    output logic [WIDTH-1:0] alu_operand2,
    output logic [2:0]       alu_aluop,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_overflow,
    output logic             ovf_sticky,
    input  logic             ovf_clear
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] op1_q, op1_d;
    logic [WIDTH-1:0] op2_q, op2_d;
    logic [2:0]       aluop_q, aluop_d;
    logic [1:0]       dst_q, dst_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_ovf_q, rsp_ovf_d;
    logic             sticky_q, sticky_d;
    logic [WIDTH-1:0] rf_q [1:3];
    logic [WIDTH-1:0] rf_d [1:3];

    logic             accept;
    logic             ovf_masked;
    logic [WIDTH-1:0] src1_val;
    logic [WIDTH-1:0] src2_val;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> EXEC on accept, EXEC -> RESP always,
    // RESP -> IDLE once the consumer takes the response.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (cmd_valid) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode of the state register.
    always_comb begin
        cmd_ready = (state_q == ST_IDLE);
        rsp_valid = (state_q == ST_RESP);
    end

    assign accept = (state_q == ST_IDLE) && cmd_valid;

    // Overflow is only meaningful for add/sub. The ALU's flag is ignored
    // for every other opcode in case it is not driven to 0 there.
    assign ovf_masked = alu_overflow && ((aluop_q == OP_ADD) || (aluop_q == OP_SUB));

    // Register file read ports; r0 always reads as zero.
    always_comb begin
        src1_val = '0;
        unique case (cmd_src1)
            2'd1:    src1_val = rf_q[1];
            2'd2:    src1_val = rf_q[2];
            2'd3:    src1_val = rf_q[3];
            default: src1_val = '0;
        endcase
    end

    always_comb begin
        src2_val = '0;
        unique case (cmd_src2)
            2'd1:    src2_val = rf_q[1];
            2'd2:    src2_val = rf_q[2];
            2'd3:    src2_val = rf_q[3];
            default: src2_val = '0;
        endcase
    end

    // Datapath next-state. Operands latch on accept and otherwise hold.
    // The result is captured and written back on the EXEC edge. That edge
    // always comes before the next accept, so no forwarding path is needed.
    always_comb begin
        op1_d      = op1_q;
        op2_d      = op2_q;
        aluop_d    = aluop_q;
        dst_d      = dst_q;
        rsp_data_d = rsp_data_q;
        rsp_ovf_d  = rsp_ovf_q;
        sticky_d   = sticky_q;
        rf_d       = rf_q;

        if (accept) begin
            op1_d   = src1_val;
            op2_d   = cmd_use_imm ? cmd_imm : src2_val;
            aluop_d = cmd_op;
            dst_d   = cmd_dst;
        end

        if (ovf_clear) begin
            sticky_d = 1'b0;
        end

        if (state_q == ST_EXEC) begin
            rsp_data_d = alu_result;
            rsp_ovf_d  = ovf_masked;
            // A new overflow beats a simultaneous clear.
            if (ovf_masked) begin
                sticky_d = 1'b1;
            end
            unique case (dst_q)
                2'd1:    rf_d[1] = alu_result;
                2'd2:    rf_d[2] = alu_result;
                2'd3:    rf_d[3] = alu_result;
                default: ;
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op1_q      <= '0;
            op2_q      <= '0;
            aluop_q    <= '0;
            dst_q      <= '0;
            rsp_data_q <= '0;
            rsp_ovf_q  <= 1'b0;
            sticky_q   <= 1'b0;
            for (int i = 1; i <= 3; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            op1_q      <= op1_d;
            op2_q      <= op2_d;
            aluop_q    <= aluop_d;
            dst_q      <= dst_d;
            rsp_data_q <= rsp_data_d;
            rsp_ovf_q  <= rsp_ovf_d;
            sticky_q   <= sticky_d;
            rf_q       <= rf_d;
        end
    end

    assign alu_operand1 = op1_q;
    assign alu_operand2 = op2_q;
    assign alu_aluop    = aluop_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_overflow = rsp_ovf_q;
    assign ovf_sticky   = sticky_q;

endmodule
